// File: rtl/hermes_periph_mux.sv
// Hermes boundary-port multiplexer. It connects N_CH peripherals to one router port.
// Outbound: round-robin arbitration at packet granularity, with optional per-channel
// release gating that is sampled only when a grant is made.
// Inbound: each packet is steered by a header field. Packets with a bad index are
// drained and counted.
module hermes_periph_mux #(
  parameter int              N_CH       = 2,
  parameter int              FLIT_SIZE  = 32,
  parameter int              CH_SEL_LSB = 16,
  parameter logic [N_CH-1:0] GATED      = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           release_i,
  input  logic [N_CH-1:0]                src_rx_i,
  output logic [N_CH-1:0]                src_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] src_data_i,
  output logic [N_CH-1:0]                dst_tx_o,
  input  logic [N_CH-1:0]                dst_credit_i,
  output logic [N_CH-1:0][FLIT_SIZE-1:0] dst_data_o,
  output logic                           noc_tx_o,
  input  logic                           noc_credit_i,
  output logic [FLIT_SIZE-1:0]           noc_data_o,
  input  logic                           noc_rx_i,
  output logic                           noc_credit_o,
  input  logic [FLIT_SIZE-1:0]           noc_data_i,
  output logic [15:0]                    drop_cnt_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {O_IDLE, O_HDR, O_SIZE, O_PAY} out_state_e;
  typedef enum logic [1:0] {I_IDLE, I_SIZE, I_PAY}        in_state_e;

  // ---------------- outbound state ----------------
  out_state_e             ostate_q, ostate_d;
  logic [CW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          ptr_q, ptr_d;
  logic [FLIT_SIZE-1:0]   ocnt_q, ocnt_d;

  // ---------------- inbound state -----------------
  in_state_e              istate_q, istate_d;
  logic [CW-1:0]          ich_q, ich_d;
  logic                   drop_q, drop_d;
  logic [FLIT_SIZE-1:0]   icnt_q, icnt_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  // ---------------- combinational helpers ---------
  logic [N_CH-1:0]        eligible;
  logic [N_CH-1:0]        elig_rot;
  logic [CW-1:0]          arb_off;
  logic [CW:0]            arb_sum;
  logic [CW-1:0]          arb_idx;
  logic                   sel_rx;
  logic [FLIT_SIZE-1:0]   sel_data;
  logic                   o_xfer, o_done;
  logic [CW-1:0]          c_raw;
  logic                   c_valid;
  logic                   i_xfer, i_done;

  // Raw (pre-reset-gating) output values.
  logic                   noc_tx_c;
  logic [FLIT_SIZE-1:0]   noc_data_c;
  logic [N_CH-1:0]        src_credit_c;
  logic [N_CH-1:0]        dst_tx_c;
  logic                   noc_credit_c;

  // Round-robin pick: rotate the eligible vector so that the pointer sits at bit 0.
  // Then take the lowest set bit and rotate the offset back.
  always_comb begin
    eligible = src_rx_i & (~GATED | {N_CH{release_i}});
    elig_rot = N_CH'({eligible, eligible} >> ptr_q);
    arb_off  = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (elig_rot[j]) arb_off = CW'(j);
    end
    arb_sum = {1'b0, ptr_q} + {1'b0, arb_off};
    if (arb_sum >= (CW + 1)'(N_CH)) arb_sum = arb_sum - (CW + 1)'(N_CH);
    arb_idx = arb_sum[CW-1:0];
  end

  // Mux the granted channel's valid and data.
  always_comb begin
    sel_rx   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q == CW'(i)) begin
        sel_rx   = src_rx_i[i];
        sel_data = src_data_i[i];
      end
    end
  end

  // Outbound next-state logic and pass-through of the granted channel.
  always_comb begin
    ostate_d     = ostate_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    ocnt_d       = ocnt_q;
    noc_tx_c     = 1'b0;
    noc_data_c   = '0;
    src_credit_c = '0;
    o_xfer       = 1'b0;
    o_done       = 1'b0;
    if (ostate_q == O_IDLE) begin
      if (|eligible) begin
        grant_d  = arb_idx;
        ostate_d = O_HDR;
      end
    end else begin
      noc_tx_c   = sel_rx;
      noc_data_c = sel_data;
      for (int i = 0; i < N_CH; i++) begin
        if (grant_q == CW'(i)) src_credit_c[i] = noc_credit_i;
      end
      o_xfer = sel_rx & noc_credit_i;
      if (o_xfer) begin
        case (ostate_q)
          O_HDR:  ostate_d = O_SIZE;
          O_SIZE: begin
            ocnt_d = sel_data;
            if (sel_data == '0) o_done = 1'b1;
            else                ostate_d = O_PAY;
          end
          default: begin
            ocnt_d = ocnt_q - FLIT_SIZE'(1);
            if (ocnt_q == FLIT_SIZE'(1)) o_done = 1'b1;
          end
        endcase
      end
      if (o_done) begin
        ostate_d = O_IDLE;
        ptr_d    = (grant_q == CW'(N_CH - 1)) ? '0 : grant_q + CW'(1);
      end
    end
  end

  // Decode the channel field of the flit at the inbound port.
  always_comb begin
    c_raw   = noc_data_i[CH_SEL_LSB +: CW];
    c_valid = ({1'b0, c_raw} < (CW + 1)'(N_CH));
  end

  // Inbound next-state logic: steer to one channel, or silently drain a bad packet.
  always_comb begin
    istate_d     = istate_q;
    ich_d        = ich_q;
    drop_d       = drop_q;
    icnt_d       = icnt_q;
    drop_cnt_d   = drop_cnt_q;
    dst_tx_c     = '0;
    noc_credit_c = 1'b0;
    i_xfer       = 1'b0;
    i_done       = 1'b0;
    if (istate_q == I_IDLE) begin
      if (noc_rx_i) begin
        if (c_valid) begin
          for (int i = 0; i < N_CH; i++) begin
            if (c_raw == CW'(i)) begin
              dst_tx_c[i]  = 1'b1;
              noc_credit_c = dst_credit_i[i];
            end
          end
          if (noc_credit_c) begin
            ich_d    = c_raw;
            istate_d = I_SIZE;
          end
        end else begin
          noc_credit_c = 1'b1;
          drop_d       = 1'b1;
          istate_d     = I_SIZE;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
    end else begin
      if (drop_q) begin
        noc_credit_c = 1'b1;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (ich_q == CW'(i)) begin
            dst_tx_c[i]  = noc_rx_i;
            noc_credit_c = dst_credit_i[i];
          end
        end
      end
      i_xfer = noc_rx_i & noc_credit_c;
      if (i_xfer) begin
        if (istate_q == I_SIZE) begin
          icnt_d = noc_data_i;
          if (noc_data_i == '0) i_done = 1'b1;
          else                  istate_d = I_PAY;
        end else begin
          icnt_d = icnt_q - FLIT_SIZE'(1);
          if (icnt_q == FLIT_SIZE'(1)) i_done = 1'b1;
        end
      end
      if (i_done) begin
        istate_d = I_IDLE;
        drop_d   = 1'b0;
      end
    end
  end

  // Outbound state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ostate_q <= O_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      ocnt_q   <= '0;
    end else begin
      ostate_q <= ostate_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      ocnt_q   <= ocnt_d;
    end
  end

  // Inbound state register and drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      istate_q   <= I_IDLE;
      ich_q      <= '0;
      drop_q     <= 1'b0;
      icnt_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      istate_q   <= istate_d;
      ich_q      <= ich_d;
      drop_q     <= drop_d;
      icnt_q     <= icnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Reset forces every output low, including the combinational pass-through paths.
  assign noc_tx_o     = noc_tx_c & ~rst_i;
  assign noc_data_o   = rst_i ? '0 : noc_data_c;
  assign src_credit_o = rst_i ? '0 : src_credit_c;
  assign dst_tx_o     = rst_i ? '0 : dst_tx_c;
  assign noc_credit_o = noc_credit_c & ~rst_i;
  assign drop_cnt_o   = drop_cnt_q;

  // The inbound flit is broadcast to all channels. Only dst_tx_o qualifies it.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_dst_data
    assign dst_data_o[gi] = rst_i ? '0 : noc_data_i;
  end

endmodule

// File: tb/tb_hermes_periph_mux.sv
// Directed bench for hermes_periph_mux (N_CH=3, channel 1 gated by release).
// Peripheral sources and the router source are modelled as flit queues.
module tb_hermes_periph_mux;

  localparam int NC = 3;
  localparam int FW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rel;
  logic [NC-1:0]        src_rx;
  logic [NC-1:0]        src_credit;
  logic [NC-1:0][FW-1:0] src_data;
  logic [NC-1:0]        dst_tx;
  logic [NC-1:0]        dst_credit;
  logic [NC-1:0][FW-1:0] dst_data;
  logic                 noc_tx;
  logic                 noc_credit;
  logic [FW-1:0]        noc_data;
  logic                 noc_rx;
  logic                 noc_cred_out;
  logic [FW-1:0]        noc_data_in;
  logic [15:0]          drop_cnt;

  always #5 clk = ~clk;

  hermes_periph_mux #(
    .N_CH(NC), .FLIT_SIZE(FW), .CH_SEL_LSB(16), .GATED(3'b010)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .release_i(rel),
    .src_rx_i(src_rx), .src_credit_o(src_credit), .src_data_i(src_data),
    .dst_tx_o(dst_tx), .dst_credit_i(dst_credit), .dst_data_o(dst_data),
    .noc_tx_o(noc_tx), .noc_credit_i(noc_credit), .noc_data_o(noc_data),
    .noc_rx_i(noc_rx), .noc_credit_o(noc_cred_out), .noc_data_i(noc_data_in),
    .drop_cnt_o(drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] srcq [NC][$];
  logic [31:0] inq [$];
  logic [31:0] out_log [$];
  int          dst_ch [$];
  logic [31:0] dst_dat [$];
  logic [31:0] exp_q [$];
  int          exp_ch [$];

  int tx_cycles, dst_any, dst0_cnt, in_stall, multi_dst, cyc;
  bit noc_cr_tog, dst_cr_tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Drive the inputs from the model queues for the current cycle.
  task automatic apply_inputs();
    for (int i = 0; i < NC; i++) begin
      src_rx[i]   = (srcq[i].size() != 0);
      src_data[i] = (srcq[i].size() != 0) ? srcq[i][0] : 32'h0;
    end
    noc_rx      = (inq.size() != 0);
    noc_data_in = (inq.size() != 0) ? inq[0] : 32'h0;
    noc_credit  = noc_cr_tog ? ~noc_credit : 1'b1;
    if (dst_cr_tog) dst_credit[1] = ~dst_credit[1];
    else            dst_credit    = 3'b111;
  endtask

  // One clock: record handshakes at the falling edge, then advance the inputs after the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (src_rx[i] && src_credit[i]) void'(srcq[i].pop_front());
    end
    if (noc_tx) tx_cycles++;
    if (noc_tx && noc_credit) out_log.push_back(noc_data);
    if (noc_rx && noc_cred_out) void'(inq.pop_front());
    if (noc_rx && !noc_cred_out) in_stall++;
    if (dst_tx != '0) dst_any++;
    if (dst_tx[0]) dst0_cnt++;
    if ($countones(dst_tx) > 1) multi_dst++;
    for (int i = 0; i < NC; i++) begin
      if (dst_tx[i] && dst_credit[i]) begin
        dst_ch.push_back(i);
        dst_dat.push_back(dst_data[i]);
      end
    end
    @(posedge clk);
    #1;
    apply_inputs();
    #1;
  endtask

  task automatic run_out(input int n, input int budget);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic run_in(input int budget, output int used);
    used = 0;
    while (inq.size() != 0 && used < budget) begin
      step();
      used++;
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_flit%0d", tag, k),
            (k < out_log.size()) ? out_log[k] : 32'hDEAD_BEEF, exp_q[k]);
  endtask

  task automatic check_dst(input string tag);
    check({tag, "_len"}, 32'(dst_dat.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s_ch%0d", tag, k),
            (k < dst_ch.size()) ? 32'(dst_ch[k]) : 32'hDEAD_BEEF, 32'(exp_ch[k]));
      check($sformatf("%s_dat%0d", tag, k),
            (k < dst_dat.size()) ? dst_dat[k] : 32'hDEAD_BEEF, exp_q[k]);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    dst_ch.delete();
    dst_dat.delete();
    tx_cycles = 0; dst_any = 0; dst0_cnt = 0; in_stall = 0;
  endtask

  initial begin
    multi_dst = 0;
    clear_logs();
    // Reset with active stimulus on every input. All outputs must still read 0.
    rst = 1'b1; rel = 1'b0; noc_cr_tog = 1'b0; dst_cr_tog = 1'b0;
    noc_credit = 1'b1; dst_credit = 3'b111;
    src_rx = 3'b111; src_data[0] = 32'h1; src_data[1] = 32'h2; src_data[2] = 32'h3;
    noc_rx = 1'b1; noc_data_in = 32'h0001_1234;
    #3;
    check("rst_noc_tx", 32'(noc_tx), 0);
    check("rst_noc_credit", 32'(noc_cred_out), 0);
    check("rst_src_credit", 32'(src_credit), 0);
    check("rst_dst_tx", 32'(dst_tx), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_noc_data", noc_data, 0);
    check("rst_dst_data1", dst_data[1], 0);
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rel = 1'b1;

    // Test 1: ch0 and ch1 request together. ch0 goes first, then ch1.
    srcq[0] = '{32'hA0, 32'd3, 32'hA1, 32'hA2, 32'hA3};
    srcq[1] = '{32'hB0, 32'd3, 32'hB1, 32'hB2, 32'hB3};
    apply_inputs();
    #1;
    check("t1_arb_tx", 32'(noc_tx), 0);
    check("t1_arb_credit", 32'(src_credit), 0);
    step();
    check("t1_hdr_tx", 32'(noc_tx), 1);
    check("t1_hdr_data", noc_data, 32'hA0);
    check("t1_hdr_credit", 32'(src_credit), 32'h1);
    run_out(10, 40);
    exp_q = '{32'hA0, 32'd3, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'd3, 32'hB1, 32'hB2, 32'hB3};
    check_out("t1");

    // Pointer now at 2: ch2 wins over ch0. S=0 packets.
    clear_logs();
    srcq[0] = '{32'hC0, 32'd0};
    srcq[2] = '{32'hD0, 32'd0};
    apply_inputs();
    run_out(4, 30);
    exp_q = '{32'hD0, 32'd0, 32'hC0, 32'd0};
    check_out("rr");

    // Test 2: gated ch1 waits for release. Dropping release mid-payload does not stop it.
    clear_logs();
    rel = 1'b0;
    srcq[1] = '{32'h11, 32'd3, 32'h12, 32'h13, 32'h14};
    apply_inputs();
    repeat (20) step();
    check("t2_gated_tx", 32'(tx_cycles), 0);
    check("t2_gated_credit", 32'(src_credit), 0);
    rel = 1'b1;
    noc_cr_tog = 1'b1;
    run_out(3, 30);
    rel = 1'b0;
    run_out(5, 30);
    noc_cr_tog = 1'b0;
    exp_q = '{32'h11, 32'd3, 32'h12, 32'h13, 32'h14};
    check_out("t2");

    // Test 3: inbound to ch1 with a toggling credit on ch1.
    clear_logs();
    dst_cr_tog = 1'b1;
    inq = '{32'h0001_0055, 32'd2, 32'h66, 32'h77};
    apply_inputs();
    #1;
    run_in(40, cyc);
    dst_cr_tog = 1'b0;
    check("t3_drained", 32'(inq.size()), 0);
    exp_q  = '{32'h0001_0055, 32'd2, 32'h66, 32'h77};
    exp_ch = '{1, 1, 1, 1};
    check_dst("t3");
    check("t3_dst0_never", 32'(dst0_cnt), 0);

    // Test 4: index 3 is invalid for 3 channels. The packet is drained and counted.
    clear_logs();
    inq = '{32'h0003_0099, 32'd4, 32'h1, 32'h2, 32'h3, 32'h4};
    apply_inputs();
    #1;
    run_in(40, cyc);
    check("t4_cycles", 32'(cyc), 6);
    check("t4_no_stall", 32'(in_stall), 0);
    check("t4_no_dst", 32'(dst_any), 0);
    check("t4_drop_cnt", 32'(drop_cnt), 1);

    // Test 5: back-to-back S=0 packets in both directions at once.
    clear_logs();
    srcq[0] = '{32'hE0, 32'd0, 32'hE1, 32'd0};
    inq     = '{32'h0000_00F0, 32'd0, 32'h0002_00F1, 32'd0};
    apply_inputs();
    #1;
    cyc = 0;
    while ((out_log.size() < 4 || inq.size() != 0) && cyc < 30) begin
      step();
      cyc++;
    end
    exp_q = '{32'hE0, 32'd0, 32'hE1, 32'd0};
    check_out("t5_out");
    exp_q  = '{32'h0000_00F0, 32'd0, 32'h0002_00F1, 32'd0};
    exp_ch = '{0, 0, 2, 2};
    check_dst("t5_in");
    check("t5_drop_cnt", 32'(drop_cnt), 1);

    // Test 6: reset in the middle of an outbound payload.
    clear_logs();
    rel = 1'b1;
    srcq[1] = '{32'h21, 32'd5, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26};
    apply_inputs();
    run_out(3, 20);
    check("t6_pre_tx", 32'(noc_tx), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(noc_tx), 0);
    check("t6_rst_credit", 32'(src_credit), 0);
    check("t6_rst_data", noc_data, 0);
    check("t6_rst_drop", 32'(drop_cnt), 0);
    inq = '{32'h0000_0077, 32'd0};
    apply_inputs();
    #1;
    check("t6_rst_dst_tx", 32'(dst_tx), 0);
    check("t6_rst_noc_cred", 32'(noc_cred_out), 0);
    check("t6_rst_dst_data", dst_data[0], 0);
    for (int i = 0; i < NC; i++) srcq[i].delete();
    inq.delete();
    apply_inputs();
    step();
    step();
    rst = 1'b0;
    clear_logs();
    srcq[0] = '{32'h31, 32'd0};
    srcq[1] = '{32'h41, 32'd0};
    apply_inputs();
    run_out(4, 20);
    exp_q = '{32'h31, 32'd0, 32'h41, 32'd0};
    check_out("t6_after");

    check("onehot_dst_tx", 32'(multi_dst), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
